// File: rtl/arb_alloc_param.sv
// arb_alloc_param: switch allocator for a 5-port YX-routed mesh router.
//
// Each output port owns a two-state (idle/busy) allocator. In idle it picks one
// requesting input by round-robin and locks that input for a whole packet. In
// busy it forwards the owner's flits while downstream credits are available.
//
// Port numbering: 0=N, 1=S, 2=W, 3=E, 4=L. Select fields are 3 bits wide.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low reset
//   yx_pos_i      this router's position {Y, X}
//   in_valid_i    per input: FIFO head valid
//   in_dest_i     per input: destination of the head flit (ADDR_W bits per slice)
//   credit_ret_i  per output: downstream freed one slot
//   in_read_o     per input: pop the input FIFO this cycle
//   out_valid_o   per output: flit driven this cycle
//   out_sel_o     per output: crossbar select (winning input), 3 bits per slice
//   in_route_o    per input: locked output, 7 when unlocked, 3 bits per slice
//   credit_err_o  per output: sticky credit-overflow flag
module arb_alloc_param #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned CREDIT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     yx_pos_i,
  input  logic [4:0]            in_valid_i,
  input  logic [5*ADDR_W-1:0]   in_dest_i,
  input  logic [4:0]            credit_ret_i,
  output logic [4:0]            in_read_o,
  output logic [4:0]            out_valid_o,
  output logic [14:0]           out_sel_o,
  output logic [14:0]           in_route_o,
  output logic [4:0]            credit_err_o
);

  localparam int unsigned NPORT = 5;
  localparam int unsigned SELW  = 3;
  localparam int unsigned HALF  = ADDR_W / 2;

  localparam logic [7:0] LAST_CNT = 8'(PKT_LEN - 1);
  localparam logic [3:0] CRED_MAX = 4'(CREDIT_MAX);

  typedef enum logic {StIdle, StBusy} state_e;

  // Wraps a sum of two values in 0..4 back into 0..4.
  function automatic logic [2:0] f_mod5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Per-output state
  state_e      r_state  [NPORT];
  state_e      w_state_nxt [NPORT];
  logic [2:0]  r_rr     [NPORT];
  logic [2:0]  w_rr_nxt [NPORT];
  logic [2:0]  r_owner  [NPORT];
  logic [2:0]  w_owner_nxt [NPORT];
  logic [7:0]  r_cnt    [NPORT];
  logic [7:0]  w_cnt_nxt [NPORT];
  logic [3:0]  r_credit [NPORT];
  logic [3:0]  w_credit_nxt [NPORT];
  logic [4:0]  r_err;
  logic [4:0]  w_err_nxt;

  // Combinational helpers
  logic [ADDR_W-1:0] w_dest  [NPORT];
  logic [2:0]        w_route [NPORT];
  logic [4:0]        w_locked;
  logic [2:0]        w_lock_port [NPORT];
  logic [4:0]        w_req [NPORT];
  logic [4:0]        w_any;
  logic [2:0]        w_win [NPORT];
  logic [4:0]        w_rd;

  // YX route per input. Unlocked inputs only use this for requests, so a
  // locked input's stale destination field is harmless.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      w_dest[i] = in_dest_i[i*ADDR_W +: ADDR_W];
      if (w_dest[i][ADDR_W-1 -: HALF] < yx_pos_i[ADDR_W-1 -: HALF]) begin
        w_route[i] = 3'd0;
      end else if (w_dest[i][ADDR_W-1 -: HALF] > yx_pos_i[ADDR_W-1 -: HALF]) begin
        w_route[i] = 3'd1;
      end else if (w_dest[i][HALF-1:0] < yx_pos_i[HALF-1:0]) begin
        w_route[i] = 3'd2;
      end else if (w_dest[i][HALF-1:0] > yx_pos_i[HALF-1:0]) begin
        w_route[i] = 3'd3;
      end else begin
        w_route[i] = 3'd4;
      end
    end
  end

  // Input lock state is derived from the busy outputs' owner registers, so an
  // input can never be held by two outputs at once.
  always_comb begin
    w_locked = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_lock_port[i] = 3'd7;
      for (int p = 0; p < NPORT; p++) begin
        if (r_state[p] == StBusy && r_owner[p] == 3'(i)) begin
          w_locked[i]    = 1'b1;
          w_lock_port[i] = 3'(p);
        end
      end
    end
  end

  // Requests and round-robin winner per output. The scan runs from the
  // furthest offset down so the nearest requester after rr ends up winning.
  always_comb begin
    w_any = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_win[p] = 3'd0;
      for (int i = 0; i < NPORT; i++) begin
        w_req[p][i] = in_valid_i[i] & ~w_locked[i] & (w_route[i] == 3'(p));
      end
      for (int k = NPORT - 1; k >= 0; k--) begin
        if (w_req[p][f_mod5(4'(r_rr[p]) + 4'(k))]) begin
          w_any[p] = 1'b1;
          w_win[p] = f_mod5(4'(r_rr[p]) + 4'(k));
        end
      end
    end
  end

  // A busy output moves a flit when its owner has data and a credit remains.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_rd[p] = (r_state[p] == StBusy) & in_valid_i[r_owner[p]] & (r_credit[p] != 4'd0);
    end
  end

  // Next-state logic
  always_comb begin
    w_err_nxt = r_err;
    for (int p = 0; p < NPORT; p++) begin
      w_state_nxt[p]  = r_state[p];
      w_rr_nxt[p]     = r_rr[p];
      w_owner_nxt[p]  = r_owner[p];
      w_cnt_nxt[p]    = r_cnt[p];
      w_credit_nxt[p] = r_credit[p];

      unique case (r_state[p])
        StIdle: begin
          if (w_any[p] && r_credit[p] != 4'd0) begin
            w_state_nxt[p] = StBusy;
            w_owner_nxt[p] = w_win[p];
          end
        end
        StBusy: begin
          if (w_rd[p]) begin
            if (r_cnt[p] == LAST_CNT) begin
              w_state_nxt[p] = StIdle;
              w_cnt_nxt[p]   = 8'd0;
              w_rr_nxt[p]    = f_mod5({1'b0, r_owner[p]} + 4'd1);
            end else begin
              w_cnt_nxt[p] = r_cnt[p] + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt[p] = StIdle;
        end
      endcase

      // Send and return in the same cycle cancel out.
      if (w_rd[p] && !credit_ret_i[p]) begin
        w_credit_nxt[p] = r_credit[p] - 4'd1;
      end else if (!w_rd[p] && credit_ret_i[p]) begin
        if (r_credit[p] == CRED_MAX) begin
          w_err_nxt[p] = 1'b1;
        end else begin
          w_credit_nxt[p] = r_credit[p] + 4'd1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) begin
        r_state[p]  <= StIdle;
        r_rr[p]     <= 3'd0;
        r_owner[p]  <= 3'd0;
        r_cnt[p]    <= 8'd0;
        r_credit[p] <= CRED_MAX;
      end
      r_err <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        r_state[p]  <= w_state_nxt[p];
        r_rr[p]     <= w_rr_nxt[p];
        r_owner[p]  <= w_owner_nxt[p];
        r_cnt[p]    <= w_cnt_nxt[p];
        r_credit[p] <= w_credit_nxt[p];
      end
      r_err <= w_err_nxt;
    end
  end

  // Outputs. All are functions of reset-cleared registers, so they take their
  // reset values as soon as reset falls.
  always_comb begin
    in_read_o    = '0;
    out_valid_o  = w_rd;
    out_sel_o    = '0;
    in_route_o   = '0;
    credit_err_o = r_err;
    for (int p = 0; p < NPORT; p++) begin
      if (r_state[p] == StBusy) begin
        out_sel_o[p*SELW +: SELW] = r_owner[p];
      end
      for (int i = 0; i < NPORT; i++) begin
        if (w_rd[p] && r_owner[p] == 3'(i)) begin
          in_read_o[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      in_route_o[i*SELW +: SELW] = w_lock_port[i];
    end
  end

endmodule

// File: tb/tb_arb_alloc_param.sv
module tb_arb_alloc_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pos;
  logic [4:0]  valid;
  logic [39:0] dest;
  logic [4:0]  ret_man;
  logic        loop_en;
  logic [4:0]  ret;
  logic [4:0]  in_read_o, out_valid_o, credit_err_o;
  logic [14:0] out_sel_o, in_route_o;

  // Second instance with shallow downstream buffers
  logic [4:0]  v2, r2, rd2, ov2, er2;
  logic [39:0] d2;
  logic [14:0] sel2, rt2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t;

  typedef struct {
    int          cyc;
    logic [4:0]  ov;
    logic [14:0] sel;
    logic [4:0]  rd;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Optional credit loopback: every sent flit is immediately returned.
  assign ret = (loop_en ? out_valid_o : 5'b0) | ret_man;

  arb_alloc_param u_dut (
    .clk          (clk),
    .reset        (rst_n),
    .yx_pos_i     (pos),
    .in_valid_i   (valid),
    .in_dest_i    (dest),
    .credit_ret_i (ret),
    .in_read_o    (in_read_o),
    .out_valid_o  (out_valid_o),
    .out_sel_o    (out_sel_o),
    .in_route_o   (in_route_o),
    .credit_err_o (credit_err_o)
  );

  arb_alloc_param #(.CREDIT_MAX(2)) u_dut2 (
    .clk          (clk),
    .reset        (rst_n),
    .yx_pos_i     (pos),
    .in_valid_i   (v2),
    .in_dest_i    (d2),
    .credit_ret_i (r2),
    .in_read_o    (rd2),
    .out_valid_o  (ov2),
    .out_sel_o    (sel2),
    .in_route_o   (rt2),
    .credit_err_o (er2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_dest(input int i, input logic [7:0] v);
    dest[i*8 +: 8] = v;
  endtask

  // Expect one flit on output p from input own during cycle c.
  task automatic push(input int c, input int p, input int own);
    ev_t e;
    e.cyc = c;
    e.ov  = 5'(1 << p);
    e.sel = 15'(own << (3 * p));
    e.rd  = 5'(1 << own);
    exp_q.push_back(e);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rd"},    32'(in_read_o),    32'h0);
    chk({tag, "_ov"},    32'(out_valid_o),  32'h0);
    chk({tag, "_sel"},   32'(out_sel_o),    32'h0);
    chk({tag, "_route"}, 32'(in_route_o),   32'h7fff);
    chk({tag, "_err"},   32'(credit_err_o), 32'h0);
  endtask

  // Monitor: every cycle that shows a flit must match the next expected one.
  always @(negedge clk) begin
    if (out_valid_o !== 5'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_flit: cyc=%0d ov=%b sel=%h rd=%b", cyc, out_valid_o,
                 out_sel_o, in_read_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || out_valid_o !== mon_e.ov || out_sel_o !== mon_e.sel ||
            in_read_o !== mon_e.rd) begin
          bad++;
          $display("FAIL flit: got cyc=%0d ov=%b sel=%h rd=%b want cyc=%0d ov=%b sel=%h rd=%b",
                   cyc, out_valid_o, out_sel_o, in_read_o, mon_e.cyc, mon_e.ov, mon_e.sel,
                   mon_e.rd);
        end
      end
    end
  end

  initial begin
    pos = 8'h22; valid = '0; dest = '0; ret_man = '0; loop_en = 1'b1;
    v2 = '0; d2 = '0; r2 = '0;
    #2 rst_n = 1'b0;
    tick(2);
    chk_rst("reset");
    rst_n = 1'b1;
    tick(1);

    // Single packet L -> E
    t = cyc;
    set_dest(4, 8'h25);
    valid = 5'b10000;
    for (int k = 1; k <= 4; k++) push(t + k, 3, 4);
    #1 chk("route_before_grant", 32'(in_route_o[14:12]), 32'd7);
    tick(1);
    chk("route_locked_E", 32'(in_route_o[14:12]), 32'd3);
    tick(4);
    valid = '0;
    chk("route_released", 32'(in_route_o[14:12]), 32'd7);
    tick(2);

    // Three inputs contending for L: order 0,2,4,0 with one idle cycle between
    t = cyc;
    set_dest(0, 8'h22); set_dest(2, 8'h22); set_dest(4, 8'h22);
    valid = 5'b10101;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) push(t + 1 + 5 * j + k, 4, (j == 3) ? 0 : 2 * j);
    tick(2);
    chk("waiter_unlocked", 32'(in_route_o[8:6]), 32'd7);
    tick(18);
    valid = '0;
    tick(2);

    // Credits on S with a U-turn from input 1, no loopback
    loop_en = 1'b0;
    t = cyc;
    set_dest(1, 8'h32);
    valid = 5'b00010;
    for (int k = 1; k <= 4; k++) push(t + k, 1, 1);
    tick(4);
    ret_man = 5'b00010;            // send + return at credit 1
    tick(1);
    ret_man = '0;
    push(t + 6, 1, 1);             // credit 1 left: one flit then stall
    tick(3);
    ret_man = 5'b00010;            // returns from t+8 on
    push(t + 9, 1, 1); push(t + 10, 1, 1); push(t + 11, 1, 1);
    tick(4);
    valid = '0;
    tick(3);
    chk("err_not_yet", 32'(credit_err_o), 32'h0);
    tick(1);
    ret_man = '0;
    chk("err_set", 32'(credit_err_o), 32'h2);
    t = cyc;                       // credit is exactly 4: one packet then nothing
    valid = 5'b00010;
    for (int k = 1; k <= 4; k++) push(t + k, 1, 1);
    tick(10);
    valid = '0;
    chk("err_sticky", 32'(credit_err_o), 32'h2);
    loop_en = 1'b1;

    // Reset mid-packet on W, then re-arbitration from rr=0
    t = cyc;
    set_dest(0, 8'h21);
    valid = 5'b00001;
    for (int k = 1; k <= 4; k++) push(t + k, 2, 0);
    tick(5);
    valid = '0;
    tick(1);
    t = cyc;
    set_dest(1, 8'h21);
    valid = 5'b00011;
    push(t + 1, 2, 1); push(t + 2, 2, 1);
    tick(3);
    rst_n = 1'b0;
    #1 chk_rst("async_reset");
    tick(2);
    rst_n = 1'b1;
    t = cyc;
    for (int k = 1; k <= 4; k++) push(t + k, 2, 0);
    tick(5);
    valid = '0;
    tick(2);

    // Bubble on N: owner drops valid for 3 cycles mid-packet
    t = cyc;
    set_dest(2, 8'h12);
    valid = 5'b00100;
    push(t + 1, 0, 2); push(t + 2, 0, 2);
    tick(3);
    valid = '0;
    tick(1);
    chk("bubble_lock_held", 32'(in_route_o[8:6]), 32'd0);
    tick(2);
    valid = 5'b00100;
    push(t + 6, 0, 2); push(t + 7, 0, 2);
    tick(2);
    valid = '0;
    chk("bubble_done", 32'(in_route_o[8:6]), 32'd7);
    tick(2);

    // CREDIT_MAX=2: two reads, stall, one return gives exactly one more read
    d2[39:32] = 8'h22;
    v2 = 5'b10000;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      r2 = (k == 6) ? 5'b10000 : 5'b0;
      #1 chk("credit2_read", 32'(rd2), (k == 1 || k == 2 || k == 7) ? 32'h10 : 32'h0);
    end
    v2 = '0;
    tick(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_flits: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_alloc_param.md
ARB_ALLOC_PARAM -- requirements
Module: arb_alloc_param

Interface
REQ-001 Parameter ADDR_W, default 8, meaning header/router address width; upper ADDR_W/2 bits = Y, lower ADDR_W/2 bits = X.
REQ-002 Parameter PKT_LEN, default 4, meaning flits per packet (head included), legal range 1..255.
REQ-003 Parameter CREDIT_MAX, default 4, meaning downstream buffer depth per output, legal range 1..15.
REQ-004 Port numbering is fixed as 5 ports: 0=N, 1=S, 2=W, 3=E, 4=L; SELW=3.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, asynchronous and active-low.
REQ-007 yx_pos_i  input  ADDR_W  this router's YX position.
REQ-008 in_valid_i  input  5  bit i: input FIFO i non-empty.
REQ-009 in_dest_i  input  5*ADDR_W  slice i: destination of the flit at FIFO i head; meaningful only when input i is not locked.
REQ-010 credit_ret_i  input  5  bit p: downstream of output p freed one slot (1-cycle pulse).
REQ-011 in_read_o  input-FIFO pop  output  5  bit i: pop FIFO i this cycle.
REQ-012 out_valid_o  output  5  bit p: flit driven on output p this cycle.
REQ-013 out_sel_o  output  5*SELW  slice p: crossbar mux select (winning input) for output p.
REQ-014 in_route_o  output  5*SELW  slice i: demux select (locked output) for input i; 7 when unlocked.
REQ-015 credit_err_o  output  5  bit p: sticky, credit return received while counter at CREDIT_MAX.

Function
REQ-016 Route SHALL be YX, combinational per unlocked input: dest Y < pos Y -> 0; Y > -> 1; Y equal and X < -> 2; X > -> 3; both equal -> 4 (unsigned compare).
REQ-017 A U-turn route (route == input index) SHALL be requested as-is; no filtering.
REQ-018 Each output p SHALL own a 2-state FSM: IDLE, BUSY; a round-robin pointer rr[p] (3 bits, 0..4); an owner register; a flit counter (8 bits); a credit counter (4 bits).
REQ-019 IDLE: requesters = unlocked inputs with in_valid_i and route == p; if any and credit[p] > 0, SHALL select first requester scanning rr[p], rr[p]+1, ... modulo 5, store owner, lock that input, go BUSY at next edge.
REQ-020 IDLE with credit[p] == 0 SHALL grant nothing and hold rr[p].
REQ-021 BUSY: out_valid_o[p] = in_read_o[owner] = in_valid_i[owner] & (credit[p] > 0), combinational; out_sel_o[p] = owner in BUSY, 0 in IDLE.
REQ-022 Each BUSY read SHALL increment flit counter; the read with counter == PKT_LEN-1 SHALL return FSM to IDLE, clear counter, unlock input, set rr[p] = owner+1 modulo 5.
REQ-023 Latency: head visible at cycle t with credit available -> grant at edge t+1 -> first in_read_o in cycle t+1; back-to-back packets from different inputs have one idle cycle between them.
REQ-024 Credit counter SHALL decrement on out_valid_o[p], increment on credit_ret_i[p]; both in the same cycle -> unchanged.
REQ-025 credit_ret_i[p] at CREDIT_MAX without simultaneous send SHALL leave counter at CREDIT_MAX and set credit_err_o[p].
REQ-026 Starvation bound: a continuously requesting input SHALL be granted within 4 packets of other inputs on that output.
REQ-027 Bubble in BUSY (in_valid_i[owner] low) SHALL hold the lock, counter and credit unchanged.
REQ-028 An input SHALL be locked to at most one output; in_read_o[i] SHALL never be asserted by two outputs.

Reset
REQ-029 While reset low: all FSMs IDLE, rr = 0, counters 0, credit = CREDIT_MAX, all inputs unlocked, credit_err_o = 0, in_read_o = 0, out_valid_o = 0, out_sel_o = 0, in_route_o = 7.
REQ-030 Reset asserted mid-packet SHALL abandon the packet immediately; no partial state survives deassertion.

Verification
REQ-031 yx_pos=0x22, in 4 dest 0x25 valid at t -> in_route_o[4]=3 at t+1, in_read_o[4] high for cycles t+1..t+4, E back to IDLE, rr[3]=0.
REQ-032 Inputs 0,2,4 all to L continuously, PKT_LEN=4 -> grant order 0,2,4,0 with one idle cycle between packets.
REQ-033 CREDIT_MAX=2, no credit_ret, 4-flit packet -> exactly 2 reads then stall; one credit_ret pulse -> exactly one further read.
REQ-034 Send and credit_ret same cycle at credit=1 -> credit stays 1; credit_ret at 4 (default) with no send -> credit_err_o set, stays set until reset.
REQ-035 Reset low after flit 2 of 4 -> all outputs at reset values asynchronously; after release, new head re-arbitrated from rr=0.
REQ-036 in_valid_i[owner] dropped for 3 cycles mid-packet -> no reads, lock held, packet completes after resume with total 4 reads.
